// File: rtl/inst_fetch.sv
// Instruction fetch stage: program memory with a loader write port and a registered fetch slot.
// It also squashes the wrong-path slot after a taken jump, detects halt and counts run cycles.
module inst_fetch #(
    parameter int unsigned   L        = 10,
    parameter int unsigned   W        = 9,
    parameter int unsigned   DEPTH    = 1024,
    parameter logic [W-1:0]  HALT_OPC = 9'h1FF
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [L-1:0] ProgCtr,
    input  logic         Taken,
    input  logic         LoadEn,
    input  logic [L-1:0] LoadAddr,
    input  logic [W-1:0] LoadData,
    output logic [W-1:0] Instr,
    output logic [L-1:0] InstrPC,
    output logic         InstrValid,
    output logic         Done,
    output logic [15:0]  CycleCnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalted
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   instr_q, instr_d;
    logic [L-1:0]   pc_q, pc_d;
    logic           valid_q, valid_d;
    logic           done_q, done_d;
    logic [15:0]    cnt_q, cnt_d;

    logic [W-1:0]   mem [DEPTH];
    logic           rd_in_range;
    logic           load_in_range;
    logic [W-1:0]   rd_data;
    logic           halt_seen;

    // Addresses past the implemented words read as the halt opcode.
    assign rd_in_range   = 32'(ProgCtr) < DEPTH;
    assign load_in_range = 32'(LoadAddr) < DEPTH;
    assign rd_data       = rd_in_range ? mem[ProgCtr[AW-1:0]] : HALT_OPC;
    assign halt_seen     = valid_q && (instr_q == HALT_OPC);

    // Memory is deliberately outside reset so a loaded program survives it.
    always_ff @(posedge Clk) begin
        if (LoadEn && load_in_range) begin
            mem[LoadAddr[AW-1:0]] <= LoadData;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = 1'b0;
        done_d  = done_q;
        cnt_d   = cnt_q;

        if (Start) begin
            state_d = StRun;
            done_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StRun: begin
                    instr_d = rd_data;
                    pc_d    = ProgCtr;
                    valid_d = !Taken;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    // The halt slot has just been presented; nothing after it is valid.
                    if (halt_seen) begin
                        state_d = StHalted;
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            instr_q <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Instr      = instr_q;
    assign InstrPC    = pc_q;
    assign InstrValid = valid_q;
    assign Done       = done_q;
    assign CycleCnt   = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, hand-written corner sequences,
// randomized traffic against a cycle-level reference model, and counter saturation.
module tb_inst_fetch;

    localparam int unsigned L     = 10;
    localparam int unsigned W     = 9;
    localparam int unsigned DEPTH = 16;
    localparam logic [8:0]  HALT  = 9'h1FF;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [L-1:0] prog_ctr = '0;
    logic         taken = 1'b0;
    logic         load_en = 1'b0;
    logic [L-1:0] load_addr = '0;
    logic [W-1:0] load_data = '0;
    logic [W-1:0] instr;
    logic [L-1:0] instr_pc;
    logic         instr_valid;
    logic         done;
    logic [15:0]  cycle_cnt;

    inst_fetch #(
        .L        (L),
        .W        (W),
        .DEPTH    (DEPTH),
        .HALT_OPC (HALT)
    ) dut (
        .Clk        (clk),
        .Reset      (reset),
        .Start      (start),
        .ProgCtr    (prog_ctr),
        .Taken      (taken),
        .LoadEn     (load_en),
        .LoadAddr   (load_addr),
        .LoadData   (load_data),
        .Instr      (instr),
        .InstrPC    (instr_pc),
        .InstrValid (instr_valid),
        .Done       (done),
        .CycleCnt   (cycle_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state, advanced once per clock from the bench's own inputs.
    logic [W-1:0] m_mem [DEPTH];
    bit           m_run;
    logic         m_valid;
    logic [W-1:0] m_instr;
    logic [L-1:0] m_pc;
    logic         m_done;
    logic [15:0]  m_cnt;

    typedef struct {
        logic         st;
        logic [L-1:0] pc;
        logic         tk;
        logic         le;
        logic [L-1:0] la;
        logic [W-1:0] ld;
        logic         ev;
        logic [W-1:0] ei;
        logic [L-1:0] ep;
        logic         ed;
        logic [15:0]  ec;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(int st, int pc, int tk, int le, int la, int ld,
                                int ev, int ei, int ep, int ed, int ec);
        vec_t v;
        v.st = st[0];
        v.pc = pc[L-1:0];
        v.tk = tk[0];
        v.le = le[0];
        v.la = la[L-1:0];
        v.ld = ld[W-1:0];
        v.ev = ev[0];
        v.ei = ei[W-1:0];
        v.ep = ep[L-1:0];
        v.ed = ed[0];
        v.ec = ec[15:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        logic [W-1:0] rd;
        logic         halt_now;
        @(posedge clk);
        rd = (32'(prog_ctr) < DEPTH) ? m_mem[int'(prog_ctr)] : HALT;
        if (reset) begin
            m_run = 0; m_valid = 0; m_instr = '0; m_pc = '0; m_done = 0; m_cnt = '0;
        end else if (start) begin
            m_run = 1; m_valid = 0; m_done = 0; m_cnt = '0;
        end else if (m_run) begin
            halt_now = m_valid && (m_instr == HALT);
            m_instr  = rd;
            m_pc     = prog_ctr;
            m_valid  = !taken && !halt_now;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (halt_now) begin
                m_run  = 0;
                m_done = 1;
            end
        end else begin
            m_valid = 0;
        end
        if (load_en && 32'(load_addr) < DEPTH) m_mem[int'(load_addr)] = load_data;
        #1;
    endtask

    task automatic load(input int addr, input int data);
        load_en   = 1'b1;
        load_addr = addr[L-1:0];
        load_data = data[W-1:0];
        step();
        load_en = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " valid"}, 32'(instr_valid), 32'(m_valid));
        chk({tag, " done"}, 32'(done), 32'(m_done));
        chk({tag, " cnt"}, 32'(cycle_cnt), 32'(m_cnt));
        if (m_valid) begin
            chk({tag, " instr"}, 32'(instr), 32'(m_instr));
            chk({tag, " pc"}, 32'(instr_pc), 32'(m_pc));
        end
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
        m_run = 0; m_valid = 0; m_instr = '0; m_pc = '0; m_done = 0; m_cnt = '0;

        // Reset state
        reset = 1'b1;
        step();
        step();
        chk("reset valid", 32'(instr_valid), 32'd0);
        chk("reset instr", 32'(instr), 32'd0);
        chk("reset pc", 32'(instr_pc), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset cnt", 32'(cycle_cnt), 32'd0);
        reset = 1'b0;

        load(0, 'h011); load(1, 'h022); load(2, 'h033); load(3, 'h1FF);
        load(5, 'h055); load(7, 'h077); load(8, 'h088); load(11, 'h0BB);
        chk("idle valid", 32'(instr_valid), 32'd0);
        chk("idle instr", 32'(instr), 32'd0);

        // start pc tk le la ld | valid instr pc done cnt
        tv.push_back(mk(1,  0, 0, 0,  0, 0,      0, 0,      0,  0, 0));
        tv.push_back(mk(0,  0, 0, 0,  0, 0,      1, 'h011,  0,  0, 1));
        tv.push_back(mk(0,  1, 0, 0,  0, 0,      1, 'h022,  1,  0, 2));
        tv.push_back(mk(0,  2, 0, 0,  0, 0,      1, 'h033,  2,  0, 3));
        tv.push_back(mk(0,  3, 0, 0,  0, 0,      1, 'h1FF,  3,  0, 4));
        tv.push_back(mk(0,  4, 0, 0,  0, 0,      0, 0,      0,  1, 5));
        tv.push_back(mk(0,  5, 1, 0,  0, 0,      0, 0,      0,  1, 5));
        tv.push_back(mk(1,  6, 0, 0,  0, 0,      0, 0,      0,  0, 0));
        tv.push_back(mk(0,  0, 0, 0,  0, 0,      1, 'h011,  0,  0, 1));
        tv.push_back(mk(0,  1, 0, 0,  0, 0,      1, 'h022,  1,  0, 2));
        tv.push_back(mk(0,  2, 1, 0,  0, 0,      0, 0,      0,  0, 3));
        tv.push_back(mk(0,  7, 0, 0,  0, 0,      1, 'h077,  7,  0, 4));
        tv.push_back(mk(0,  8, 0, 0,  0, 0,      1, 'h088,  8,  0, 5));
        tv.push_back(mk(0,  9, 1, 0,  0, 0,      0, 0,      0,  0, 6));
        tv.push_back(mk(0, 10, 1, 0,  0, 0,      0, 0,      0,  0, 7));
        tv.push_back(mk(0, 11, 0, 0,  0, 0,      1, 'h0BB, 11,  0, 8));
        tv.push_back(mk(1, 12, 0, 0,  0, 0,      0, 0,      0,  0, 0));
        tv.push_back(mk(0,  0, 0, 0,  0, 0,      1, 'h011,  0,  0, 1));
        tv.push_back(mk(0,  5, 0, 1,  5, 'h155,  1, 'h055,  5,  0, 2));
        tv.push_back(mk(0,  5, 0, 0,  0, 0,      1, 'h155,  5,  0, 3));
        tv.push_back(mk(0, 16, 0, 1, 16, 'h1FF,  1, 'h1FF, 16,  0, 4));
        tv.push_back(mk(0, 17, 0, 0,  0, 0,      0, 0,      0,  1, 5));
        tv.push_back(mk(1,  0, 0, 0,  0, 0,      0, 0,      0,  0, 0));
        tv.push_back(mk(0,  0, 0, 0,  0, 0,      1, 'h011,  0,  0, 1));

        foreach (tv[i]) begin
            start     = tv[i].st;
            prog_ctr  = tv[i].pc;
            taken     = tv[i].tk;
            load_en   = tv[i].le;
            load_addr = tv[i].la;
            load_data = tv[i].ld;
            step();
            chk($sformatf("tv%0d valid", i), 32'(instr_valid), 32'(tv[i].ev));
            chk($sformatf("tv%0d done", i), 32'(done), 32'(tv[i].ed));
            chk($sformatf("tv%0d cnt", i), 32'(cycle_cnt), 32'(tv[i].ec));
            if (tv[i].ev) begin
                chk($sformatf("tv%0d instr", i), 32'(instr), 32'(tv[i].ei));
                chk($sformatf("tv%0d pc", i), 32'(instr_pc), 32'(tv[i].ep));
            end
        end
        start = 1'b0; taken = 1'b0; load_en = 1'b0;

        // Reset during RUN: outputs clear, Start ignored under Reset, program retained
        prog_ctr = 10'd1;
        step();
        chk("rr pre instr", 32'(instr), 32'h022);
        reset = 1'b1; start = 1'b1; prog_ctr = 10'd2;
        step();
        chk("rr valid", 32'(instr_valid), 32'd0);
        chk("rr instr", 32'(instr), 32'd0);
        chk("rr pc", 32'(instr_pc), 32'd0);
        chk("rr done", 32'(done), 32'd0);
        chk("rr cnt", 32'(cycle_cnt), 32'd0);
        reset = 1'b0; start = 1'b0; prog_ctr = 10'd3;
        step();
        chk("rr idle valid", 32'(instr_valid), 32'd0);
        chk("rr idle instr", 32'(instr), 32'd0);
        chk("rr idle cnt", 32'(cycle_cnt), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0; prog_ctr = 10'd0;
        step();
        chk("rr kept valid", 32'(instr_valid), 32'd1);
        chk("rr kept instr", 32'(instr), 32'h011);

        // Randomized traffic against the model
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int a = 0; a < int'(DEPTH); a++) begin
            load(a, ($urandom_range(0, 7) == 0) ? int'(HALT) : int'($urandom_range(0, 510)));
        end
        for (int c = 0; c < 2000; c++) begin
            reset    = ($urandom_range(0, 63) == 0);
            start    = ($urandom_range(0, 11) == 0);
            taken    = ($urandom_range(0, 3) == 0);
            prog_ctr = ($urandom_range(0, 15) == 0) ? L'(16 + $urandom_range(0, 3))
                                                    : L'($urandom_range(0, 15));
            load_en   = ($urandom_range(0, 3) == 0);
            load_addr = L'($urandom_range(0, 19));
            load_data = ($urandom_range(0, 15) == 0) ? HALT : W'($urandom_range(0, 510));
            step();
            chk_model($sformatf("rnd%0d", c));
        end
        reset = 1'b0; start = 1'b0; taken = 1'b0; load_en = 1'b0;

        // Counter saturation
        reset = 1'b1;
        step();
        reset = 1'b0;
        load(0, 'h011);
        start = 1'b1;
        step();
        start = 1'b0; prog_ctr = 10'd0;
        repeat (65534) step();
        chk("sat pre", 32'(cycle_cnt), 32'hFFFE);
        step();
        chk("sat max", 32'(cycle_cnt), 32'hFFFF);
        step();
        chk("sat hold", 32'(cycle_cnt), 32'hFFFF);
        chk("sat valid", 32'(instr_valid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
